// File: rtl/osmanip_mem_seq_master.sv
// osmanip_mem_seq_master: Avalon-MM fill/check sequencer for the osmanip on-chip RAM.
// Fill writes seed+i over a block of words. Check reads the block back, compares each
// word against seed+i and reports the mismatch count, first failing address and a sum.
module osmanip_mem_seq_master #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_op,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [ADDR_W:0]     cmd_len,
    input  logic [DATA_W-1:0]   cmd_seed,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     mismatch_cnt,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   sum,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest
);
    localparam int unsigned     LenW   = ADDR_W + 1;
    localparam logic [LenW-1:0] MaxLen = LenW'(2 ** ADDR_W);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] seed_q;
    logic [LenW-1:0]   len_q;
    logic [LenW-1:0]   idx_q;

    // Read-tag pipeline: stage 0 receives the tag of the read accepted at this edge,
    // the last stage lines up with the cycle its readdata is valid.
    logic [READ_LATENCY-1:0] tag_v_q;
    logic [LenW-1:0]         tag_idx_q [READ_LATENCY];

    logic [LenW-1:0] len_clamped;
    logic [LenW-1:0] ret_idx;
    logic            last_beat;
    logic            push;
    logic            pending;
    logic            ret_valid;
    logic            ret_bad;

    // Decode beat/return conditions and whether reads remain behind the exiting tag.
    always_comb begin
        len_clamped = (cmd_len > MaxLen) ? MaxLen : cmd_len;
        last_beat   = (idx_q == len_q - 1'b1);
        // chipselect is held high for the whole READ state
        push        = (state_q == StRead) && !avm_waitrequest;
        ret_valid   = tag_v_q[READ_LATENCY-1];
        ret_idx     = tag_idx_q[READ_LATENCY-1];
        ret_bad     = (avm_readdata != (seed_q + DATA_W'(ret_idx)));
        pending     = 1'b0;
        for (int i = 0; i < int'(READ_LATENCY) - 1; i++) begin
            pending = pending | tag_v_q[i];
        end
    end

    // Sequencer FSM with registered bus and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            seed_q         <= '0;
            len_q          <= '0;
            idx_q          <= '0;
            tag_v_q        <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                tag_idx_q[i] <= '0;
            end
            cmd_ready      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mismatch_cnt   <= '0;
            first_err_addr <= '0;
            sum            <= '0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= '0;
            avm_writedata  <= '0;
        end else begin
            for (int i = int'(READ_LATENCY) - 1; i > 0; i--) begin
                tag_v_q[i]   <= tag_v_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
            tag_v_q[0]   <= push;
            tag_idx_q[0] <= idx_q;

            if (ret_valid) begin
                sum <= sum + avm_readdata;
                if (ret_bad) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                    if (mismatch_cnt == '0) begin
                        first_err_addr <= addr_q + ret_idx[ADDR_W-1:0];
                    end
                end
            end

            done <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        addr_q         <= cmd_addr;
                        seed_q         <= cmd_seed;
                        len_q          <= len_clamped;
                        idx_q          <= '0;
                        cmd_ready      <= 1'b0;
                        busy           <= 1'b1;
                        mismatch_cnt   <= '0;
                        first_err_addr <= '0;
                        sum            <= '0;
                        if (len_clamped == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q        <= cmd_op ? StRead : StWrite;
                            avm_chipselect <= 1'b1;
                            avm_write      <= !cmd_op;
                            avm_byteenable <= '1;
                            avm_address    <= cmd_addr;
                            avm_writedata  <= cmd_op ? '0 : cmd_seed;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                StWrite: begin
                    if (!avm_waitrequest) begin
                        if (last_beat) begin
                            avm_chipselect <= 1'b0;
                            avm_write      <= 1'b0;
                            avm_byteenable <= '0;
                            state_q        <= StDone;
                            done           <= 1'b1;
                        end else begin
                            idx_q         <= idx_q + 1'b1;
                            avm_address   <= avm_address + 1'b1;
                            avm_writedata <= avm_writedata + 1'b1;
                        end
                    end
                end
                StRead: begin
                    if (!avm_waitrequest) begin
                        if (last_beat) begin
                            avm_chipselect <= 1'b0;
                            avm_byteenable <= '0;
                            state_q        <= StDrain;
                        end else begin
                            idx_q       <= idx_q + 1'b1;
                            avm_address <= avm_address + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    // The tag leaving this edge is the last one once no earlier stage is full
                    if (!pending) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                    end
                end
                StDone: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_osmanip_mem_seq_master.sv
// Bench for osmanip_mem_seq_master: instance 0 uses READ_LATENCY=1 with no stalls,
// instance 1 uses READ_LATENCY=3 with random waitrequest. Each has its own RAM model.
module tb_osmanip_mem_seq_master;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = AW + 1;

    typedef struct {
        int            inst;
        string         name;
        logic [LW-1:0] mism;
        logic [AW-1:0] ferr;
        logic [DW-1:0] sum;
        int            cycles;
        int            beats;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            cmd_valid       [2];
    logic            cmd_ready       [2];
    logic            cmd_op          [2];
    logic [AW-1:0]   cmd_addr        [2];
    logic [LW-1:0]   cmd_len         [2];
    logic [DW-1:0]   cmd_seed        [2];
    logic            busy            [2];
    logic            done            [2];
    logic [LW-1:0]   mismatch_cnt    [2];
    logic [AW-1:0]   first_err_addr  [2];
    logic [DW-1:0]   sum             [2];
    logic [AW-1:0]   avm_address     [2];
    logic            avm_chipselect  [2];
    logic            avm_write       [2];
    logic [DW/8-1:0] avm_byteenable  [2];
    logic [DW-1:0]   avm_writedata   [2];
    logic [DW-1:0]   avm_readdata    [2];
    logic            avm_waitrequest [2];

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int Lat = (g == 0) ? 1 : 3;
        logic [DW-1:0] mem   [1024];
        logic [DW-1:0] rpipe [Lat];
        logic          wait_l = 1'b0;

        osmanip_mem_seq_master #(
            .ADDR_W       (AW),
            .DATA_W       (DW),
            .READ_LATENCY (Lat)
        ) u_dut (
            .clk             (clk),
            .reset_n         (rst_n),
            .cmd_valid       (cmd_valid[g]),
            .cmd_ready       (cmd_ready[g]),
            .cmd_op          (cmd_op[g]),
            .cmd_addr        (cmd_addr[g]),
            .cmd_len         (cmd_len[g]),
            .cmd_seed        (cmd_seed[g]),
            .busy            (busy[g]),
            .done            (done[g]),
            .mismatch_cnt    (mismatch_cnt[g]),
            .first_err_addr  (first_err_addr[g]),
            .sum             (sum[g]),
            .avm_address     (avm_address[g]),
            .avm_chipselect  (avm_chipselect[g]),
            .avm_write       (avm_write[g]),
            .avm_byteenable  (avm_byteenable[g]),
            .avm_writedata   (avm_writedata[g]),
            .avm_readdata    (avm_readdata[g]),
            .avm_waitrequest (avm_waitrequest[g])
        );

        assign avm_readdata[g]    = rpipe[Lat-1];
        assign avm_waitrequest[g] = wait_l;

        // RAM slave: fixed read latency, junk on the data bus when no read returns
        always @(posedge clk) begin
            for (int i = Lat - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
            if (avm_chipselect[g] && !avm_waitrequest[g] && !avm_write[g])
                rpipe[0] <= mem[avm_address[g]];
            else
                rpipe[0] <= 32'hBAD0_BAD0;
            if (avm_chipselect[g] && !avm_waitrequest[g] && avm_write[g])
                mem[avm_address[g]] <= avm_writedata[g];
        end

        initial forever begin
            @(posedge clk);
            #2;
            wait_l = (Lat > 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
    end

    exp_t          exp_q [$];
    logic [AW+DW-1:0] wr_q [$];
    int checks = 0;
    int errors = 0;
    int done_cnt  [2];
    bit active    [2];
    int cyc       [2];
    int beats     [2];
    bit prev_done [2];
    bit hold      [2];
    logic [AW-1:0] h_addr [2];
    logic [DW-1:0] h_data [2];
    logic          h_wr   [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic mon_step(input int g);
        exp_t e;
        logic [AW+DW-1:0] w;
        if (!rst_n) begin
            active[g]    = 1'b0;
            hold[g]      = 1'b0;
            prev_done[g] = 1'b0;
            return;
        end
        if (hold[g]) begin
            chk("stall_addr", avm_address[g], h_addr[g]);
            chk("stall_data", avm_writedata[g], h_data[g]);
            chk("stall_cs_wr", {avm_chipselect[g], avm_write[g]}, {1'b1, h_wr[g]});
        end
        hold[g]   = avm_chipselect[g] && avm_waitrequest[g];
        h_addr[g] = avm_address[g];
        h_data[g] = avm_writedata[g];
        h_wr[g]   = avm_write[g];
        if (avm_chipselect[g] && !avm_waitrequest[g]) begin
            chk("byteenable", avm_byteenable[g], 4'hF);
            if (g == 0 && avm_write[0]) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write_trace: got write 0x%0h<-0x%0h, required none",
                             avm_address[0], avm_writedata[0]);
                end else begin
                    w = wr_q.pop_front();
                    chk("write_addr", avm_address[0], w[AW+DW-1:DW]);
                    chk("write_data", avm_writedata[0], w[DW-1:0]);
                end
            end
        end
        if (active[g]) begin
            cyc[g]++;
            if (avm_chipselect[g] && !avm_waitrequest[g]) beats[g]++;
        end
        if (cmd_valid[g] && cmd_ready[g]) begin
            active[g] = 1'b1;
            cyc[g]    = 0;
            beats[g]  = 0;
        end
        if (done[g]) begin
            chk("done_one_cycle", prev_done[g], 1'b0);
            chk("busy_at_done", busy[g], 1'b1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done on inst %0d, required none", g);
            end else begin
                e = exp_q.pop_front();
                chk({e.name, "_inst"}, g, e.inst);
                chk({e.name, "_mism"}, mismatch_cnt[g], e.mism);
                chk({e.name, "_ferr"}, first_err_addr[g], e.ferr);
                chk({e.name, "_sum"}, sum[g], e.sum);
                chk({e.name, "_beats"}, beats[g], e.beats);
                if (e.cycles >= 0) chk({e.name, "_cycles"}, cyc[g], e.cycles);
            end
            active[g] = 1'b0;
            done_cnt[g]++;
        end
        prev_done[g] = done[g];
    endtask

    initial forever begin
        @(negedge clk);
        for (int g = 0; g < 2; g++) mon_step(g);
    end

    task automatic issue(input int g, input bit op, input int addr, input int len,
                         input logic [DW-1:0] seed);
        int n;
        @(posedge clk);
        #1;
        cmd_op[g]    = op;
        cmd_addr[g]  = AW'(addr);
        cmd_len[g]   = LW'(len);
        cmd_seed[g]  = seed;
        cmd_valid[g] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready[g] && n < 100);
        chk("handshake", cmd_ready[g], 1'b1);
        @(posedge clk);
        #1;
        cmd_valid[g] = 1'b0;
    endtask

    task automatic wait_done(input int g);
        int start;
        int n;
        start = done_cnt[g];
        n = 0;
        while (done_cnt[g] == start && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", done_cnt[g] != start, 1'b1);
    endtask

    // Run one command: queue expected results (and write trace for instance 0), then wait.
    task automatic run(input int g, input string name, input bit op, input int addr,
                       input int len, input logic [DW-1:0] seed, input int mism,
                       input int ferr, input logic [DW-1:0] s, input int cycles,
                       input int nbeats);
        exp_t e;
        e.inst = g; e.name = name; e.mism = LW'(mism); e.ferr = AW'(ferr);
        e.sum = s; e.cycles = cycles; e.beats = nbeats;
        exp_q.push_back(e);
        if (g == 0 && !op) begin
            for (int i = 0; i < nbeats; i++)
                wr_q.push_back({AW'(addr + i), seed + DW'(i)});
        end
        issue(g, op, addr, len, seed);
        wait_done(g);
    endtask

    task automatic check_reset_outputs(input int g);
        chk("rst_cmd_ready", cmd_ready[g], 1'b0);
        chk("rst_busy", busy[g], 1'b0);
        chk("rst_done", done[g], 1'b0);
        chk("rst_cs", avm_chipselect[g], 1'b0);
        chk("rst_write", avm_write[g], 1'b0);
        chk("rst_be", avm_byteenable[g], 4'h0);
        chk("rst_results", {mismatch_cnt[g], first_err_addr[g], sum[g]}, 64'h0);
        chk("rst_bus", {avm_address[g], avm_writedata[g]}, 64'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        for (int g = 0; g < 2; g++) begin
            cmd_valid[g] = 1'b0; cmd_op[g] = 1'b0; cmd_addr[g] = '0;
            cmd_len[g] = '0; cmd_seed[g] = '0;
        end
        rst_n = 1'b0;
        #23;
        for (int g = 0; g < 2; g++) check_reset_outputs(g);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", cmd_ready[0], 1'b1);

        // Instance 0: READ_LATENCY=1, no stalls, exact cycle counts
        run(0, "fill0",     0, 0,    4,    32'h10,       0, 0,    32'h0,       5,    4);
        run(0, "chk0",      1, 0,    4,    32'h10,       0, 0,    32'h46,      6,    4);
        run(0, "fillwrap",  0, 1022, 4,    32'hFFFFFFFE, 0, 0,    32'h0,       5,    4);
        run(0, "chkwrap",   1, 1022, 4,    32'hFFFFFFFE, 0, 0,    32'hFFFFFFFE, 6,   4);
        run(0, "chklow",    1, 0,    2,    32'h0,        0, 0,    32'h1,       4,    2);
        run(0, "fill8",     0, 0,    8,    32'h0,        0, 0,    32'h0,       9,    8);
        run(0, "corrupt",   0, 5,    1,    32'hDEAD,     0, 0,    32'h0,       2,    1);
        run(0, "chkbad",    1, 0,    8,    32'h0,        1, 5,    32'hDEC4,    10,   8);
        run(0, "chkmulti",  1, 1022, 4,    32'h0,        4, 1022, 32'hFFFFFFFE, 6,   4);
        run(0, "len0",      1, 3,    0,    32'h5,        0, 0,    32'h0,       1,    0);
        run(0, "clamp",     0, 0,    2047, 32'h100,      0, 0,    32'h0,       1025, 1024);

        // Instance 1: READ_LATENCY=3 with random stalls, same results expected
        run(1, "s_fill0",   0, 0,    4,    32'h10,       0, 0,    32'h0,       -1,   4);
        run(1, "s_chk0",    1, 0,    4,    32'h10,       0, 0,    32'h46,      -1,   4);
        run(1, "s_fillwrap",0, 1022, 4,    32'hFFFFFFFE, 0, 0,    32'h0,       -1,   4);
        run(1, "s_chkwrap", 1, 1022, 4,    32'hFFFFFFFE, 0, 0,    32'hFFFFFFFE, -1,  4);
        run(1, "s_chklow",  1, 0,    2,    32'h0,        0, 0,    32'h1,       -1,   2);
        run(1, "s_fill8",   0, 0,    8,    32'h0,        0, 0,    32'h0,       -1,   8);
        run(1, "s_corrupt", 0, 5,    1,    32'hDEAD,     0, 0,    32'h0,       -1,   1);
        run(1, "s_chkbad",  1, 0,    8,    32'h0,        1, 5,    32'hDEC4,    -1,   8);

        // Reset in the middle of a check on instance 0: abandoned with no done
        saved = done_cnt[0];
        issue(0, 1, 0, 8, 32'h100);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_cs", avm_chipselect[0], 1'b0);
        chk("midrst_busy", busy[0], 1'b0);
        chk("midrst_ready", cmd_ready[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_no_done", done_cnt[0], saved);
        run(0, "after_rst", 1, 0,    8,    32'h100,      0, 0,    32'h81C,     10,   8);

        repeat (3) @(negedge clk);
        chk("exp_queue_empty", exp_q.size(), 0);
        chk("write_queue_empty", wr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
